// File: rtl/ripple_capture_pkg.sv
// Shared defaults and the wrap-aware delta helper for the ripple capture block.
package ripple_capture_pkg;

  // Default widths and FIFO depth, reused as parameter defaults everywhere.
  localparam int CNT_W_DEF = 4;
  localparam int ACC_W_DEF = 16;
  localparam int DEPTH_DEF = 4;

  // Distance travelled by the ripple counter between two accepted samples,
  // taken modulo 2^cnt_w so a wrap through zero counts as a single step.
  // A down counter moves from last_v towards cur_v by (last_v - cur_v);
  // an up counter by (cur_v - last_v).
  function automatic logic [31:0] ripple_delta(
    input logic [31:0] last_v,
    input logic [31:0] cur_v,
    input int unsigned cnt_w,
    input logic        down
  );
    logic [31:0] diff;
    logic [31:0] mask;
    diff = down ? (last_v - cur_v) : (cur_v - last_v);
    mask = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
    return diff & mask;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding accumulator snapshots. The head value is
// held after the last entry is popped so the consumer side does not see
// stale memory contents once the queue runs dry.
module sync_fifo
  import ripple_capture_pkg::*;
#(
  parameter int WIDTH = ACC_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);

  // A pop frees a slot in the same edge, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Once empty, present the last value that left the FIFO instead of memory.
  assign head_o = empty_o ? hold_q : mem_q[rd_q];

  // Pointer, occupancy and held-head next state.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (do_push) begin
      wr_d = wr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_d   = rd_q + PTR_W'(1);
      hold_d = mem_q[rd_q];
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (PTR_W + 1)'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - (PTR_W + 1)'(1);
    end
  end

  // Control registers; reset empties the FIFO and clears the held head.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

  // Storage array; contents are meaningless while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (rstn && do_push) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ripple_capture.sv
// Captures an asynchronous ripple counter into the clk domain, filters out
// samples taken mid-ripple, extends the count into a wide accumulator and
// queues on-demand snapshots of that accumulator for a downstream consumer.
module ripple_capture
  import ripple_capture_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DOWN  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             snap_req,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_now,
  output logic             ovf
);

  // Synchronizer stages s1/s2 plus history flop s3 used for the stability test.
  logic [CNT_W-1:0] s1_q, s2_q, s3_q;
  // Marks which synchronizer stages hold a sample taken since reset, so the
  // zeroed reset contents are never mistaken for a stable counter value.
  logic [2:0]       fill_q;

  logic [CNT_W-1:0] last_q, last_d;
  logic             primed_q, primed_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic             sample_ok;
  logic [ACC_W-1:0] delta;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             drop;

  // A sample is usable when s2 has settled (matches s3) and s3 holds a real
  // post-reset sample rather than a reset value.
  assign sample_ok = fill_q[2] && (s2_q == s3_q);

  assign delta = ACC_W'(ripple_delta(32'(last_q), 32'(s2_q),
                                     unsigned'(CNT_W), (DOWN != 0)));

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign drop      = snap_req && fifo_full && !fifo_pop;

  assign acc_now = acc_q;
  assign ovf     = ovf_q;

  // Synchronizer chain and fill tracking for the asynchronous counter input.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      fill_q <= '0;
    end else begin
      s1_q   <= cnt_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  // Priming, accumulation and sticky overflow next state. The first settled
  // sample only seeds last; later settled changes add the wrapped distance.
  always_comb begin
    last_d   = last_q;
    primed_d = primed_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q | drop;
    if (sample_ok) begin
      if (!primed_q) begin
        last_d   = s2_q;
        primed_d = 1'b1;
      end else if (s2_q != last_q) begin
        last_d = s2_q;
        acc_d  = acc_q + delta;
      end
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_q   <= '0;
      primed_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      last_q   <= last_d;
      primed_q <= primed_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  // Snapshot queue; the pushed value is the accumulator as seen before the
  // edge, so a same-edge accumulator update is never captured.
  sync_fifo #(
    .WIDTH(ACC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (snap_req),
    .push_data_i (acc_q),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (out_data)
  );

endmodule

// File: tb/tb_ripple_capture.sv
// Self-checking bench for ripple_capture with a queue-based reference model.
module tb_ripple_capture;

  localparam int CNT_W = 4;
  localparam int ACC_W = 16;
  localparam int DEPTH = 4;
  localparam int DOWN  = 1;

  logic             clk = 1'b0;
  logic             rstn;
  logic [CNT_W-1:0] cnt_in;
  logic             snap_req;
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_now;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: history of every sampled input since reset,
  // the extended count, and a plain queue standing in for the FIFO.
  int               hist[$];
  logic [ACC_W-1:0] m_acc;
  int               m_last;
  bit               m_primed;
  logic [ACC_W-1:0] m_q[$];
  logic [ACC_W-1:0] m_hold;
  bit               m_ovf;

  always #5 clk = ~clk;

  ripple_capture #(
    .CNT_W(CNT_W),
    .ACC_W(ACC_W),
    .DEPTH(DEPTH),
    .DOWN (DOWN)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cnt_in    (cnt_in),
    .snap_req  (snap_req),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_now   (acc_now),
    .ovf       (ovf)
  );

  // Model one rising edge. A counter value is trusted when the value seen
  // two edges ago equals the one seen three edges ago (it survived two
  // synchronizer stages unchanged).
  task automatic model_edge();
    int  len;
    int  v;
    int  d;
    bit  pop;
    bit  was_full;
    if (!rstn) begin
      hist.delete();
      m_q.delete();
      m_acc    = '0;
      m_last   = 0;
      m_primed = 0;
      m_hold   = '0;
      m_ovf    = 0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      pop      = (m_q.size() > 0) && out_ready;
      if (snap_req && was_full && !pop) m_ovf = 1;
      if (pop) m_hold = m_q.pop_front();
      if (snap_req && (!was_full || pop)) m_q.push_back(m_acc);
      len = hist.size();
      if (len >= 3 && hist[len-2] == hist[len-3]) begin
        v = hist[len-2];
        if (!m_primed) begin
          m_primed = 1;
          m_last   = v;
        end else if (v != m_last) begin
          d = (DOWN != 0) ? (m_last - v) : (v - m_last);
          d = d & ((1 << CNT_W) - 1);
          m_acc  = m_acc + ACC_W'(d);
          m_last = v;
        end
      end
      hist.push_back(int'(cnt_in));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic hold(input int v, input int n);
    cnt_in = CNT_W'(v);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    snap_req = 1'b0;
    out_ready = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    cnt_in = 4'd9;
    snap_req = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    n_checks++;
    if (acc_now !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_acc: got %0d expected 0", acc_now); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %0b expected 0", out_valid); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf: got %0b expected 0", ovf); end
    n_checks++;
    if (out_data !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_data: got %0d expected 0", out_data); end
    rstn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_checks++;
      if (acc_now !== 16'd0) begin n_fail++; $display("[TB] FAIL prime_acc edge %0d: got %0d expected 0", i, acc_now); end
      n_checks++;
      if (dut.primed_q !== (i >= 4)) begin n_fail++; $display("[TB] FAIL prime_flag edge %0d: got %0b expected %0b", i, dut.primed_q, (i >= 4)); end
    end
  endtask

  task automatic test_steps();
    do_reset();
    hold(5, 6);
    n_checks++;
    if (acc_now !== 16'd0) begin n_fail++; $display("[TB] FAIL steps_primed: got %0d expected 0", acc_now); end
    cnt_in = 4'd4;
    for (int i = 1; i <= 6; i++) begin
      step();
      n_checks++;
      if (acc_now !== ((i >= 4) ? 16'd1 : 16'd0)) begin n_fail++; $display("[TB] FAIL steps_5to4 edge %0d: got %0d expected %0d", i, acc_now, (i >= 4) ? 1 : 0); end
    end
    cnt_in = 4'd3;
    for (int i = 1; i <= 6; i++) begin
      step();
      n_checks++;
      if (acc_now !== ((i >= 4) ? 16'd2 : 16'd1)) begin n_fail++; $display("[TB] FAIL steps_4to3 edge %0d: got %0d expected %0d", i, acc_now, (i >= 4) ? 2 : 1); end
    end
  endtask

  // Continues from test_steps: acc = 2, last accepted value = 3.
  task automatic test_wrap();
    int prev;
    int v;
    hold(0, 6);
    n_checks++;
    if (acc_now !== 16'd5) begin n_fail++; $display("[TB] FAIL wrap_3to0: got %0d expected 5", acc_now); end
    hold(15, 6);
    n_checks++;
    if (acc_now !== 16'd6) begin n_fail++; $display("[TB] FAIL wrap_0to15: got %0d expected 6", acc_now); end
    hold(2, 6);
    n_checks++;
    if (acc_now !== 16'd19) begin n_fail++; $display("[TB] FAIL wrap_15to2: got %0d expected 19", acc_now); end
    hold(14, 6);
    n_checks++;
    if (acc_now !== 16'd23) begin n_fail++; $display("[TB] FAIL wrap_2to14: got %0d expected 23", acc_now); end
    prev = 14;
    for (int i = 0; i < 20; i++) begin
      v = (prev + 1 + int'($urandom_range(14))) % 16;
      cnt_in = CNT_W'(v);
      prev = v;
      step();
      n_checks++;
      if (acc_now !== 16'd23) begin n_fail++; $display("[TB] FAIL wrap_toggle cycle %0d: got %0d expected 23", i, acc_now); end
    end
    hold(prev, 6);
    n_checks++;
    if (acc_now !== m_acc) begin n_fail++; $display("[TB] FAIL wrap_settle: got %0d expected %0d", acc_now, m_acc); end
  endtask

  task automatic test_snapshot();
    do_reset();
    hold(7, 5);
    hold(0, 5);
    n_checks++;
    if (acc_now !== 16'd7) begin n_fail++; $display("[TB] FAIL snap_acc: got %0d expected 7", acc_now); end
    snap_req = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL snap_no_bypass: got %0b expected 0", out_valid); end
    step();
    snap_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL snap_valid cycle %0d: got %0b expected 1", i, out_valid); end
      n_checks++;
      if (out_data !== 16'd7) begin n_fail++; $display("[TB] FAIL snap_data cycle %0d: got %0d expected 7", i, out_data); end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL snap_popped: got %0b expected 0", out_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    hold(10, 5);
    for (int k = 1; k <= 5; k++) begin
      hold(10 - k, 5);
      n_checks++;
      if (acc_now !== ACC_W'(k)) begin n_fail++; $display("[TB] FAIL ovf_acc %0d: got %0d expected %0d", k, acc_now, k); end
      snap_req = 1'b1;
      step();
      snap_req = 1'b0;
      if (k == 4) begin
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_early: got %0b expected 0", ovf); end
      end
    end
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set: got %0b expected 1", ovf); end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (out_data !== ACC_W'(k)) begin n_fail++; $display("[TB] FAIL ovf_drain %0d: got %0d expected %0d", k, out_data, k); end
      step();
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_drained: got %0b expected 0", out_valid); end
    for (int k = 6; k <= 9; k++) begin
      hold(10 - k, 5);
      snap_req = 1'b1;
      step();
      snap_req = 1'b0;
    end
    hold(0, 5);
    n_checks++;
    if (acc_now !== 16'd10) begin n_fail++; $display("[TB] FAIL ovf_acc10: got %0d expected 10", acc_now); end
    snap_req = 1'b1;
    out_ready = 1'b1;
    step();
    snap_req = 1'b0;
    n_checks++;
    if (ovf !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky: got %0b expected 1", ovf); end
    for (int k = 7; k <= 10; k++) begin
      n_checks++;
      if (out_data !== ACC_W'(k) || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_order %0d: got %0d valid %0b expected %0d", k, out_data, out_valid, k); end
      step();
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_final_empty: got %0b expected 0", out_valid); end
  endtask

  task automatic test_midreset();
    do_reset();
    hold(4, 5);
    hold(0, 5);
    snap_req = 1'b1; step(); snap_req = 1'b0;
    hold(12, 5);
    snap_req = 1'b1; step(); snap_req = 1'b0;
    hold(8, 5);
    snap_req = 1'b1; step(); snap_req = 1'b0;
    hold(4, 5);
    hold(0, 5);
    n_checks++;
    if (acc_now !== 16'd20 || out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_setup: got acc %0d valid %0b expected 20 1", acc_now, out_valid); end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_valid: got %0b expected 0", out_valid); end
    n_checks++;
    if (acc_now !== 16'd0) begin n_fail++; $display("[TB] FAIL mid_acc: got %0d expected 0", acc_now); end
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_ovf: got %0b expected 0", ovf); end
    for (int i = 1; i <= 6; i++) begin
      step();
      n_checks++;
      if (dut.primed_q !== (i >= 4) || acc_now !== 16'd0) begin n_fail++; $display("[TB] FAIL mid_prime edge %0d: got primed %0b acc %0d expected %0b 0", i, dut.primed_q, acc_now, (i >= 4)); end
    end
    hold(3, 6);
    n_checks++;
    if (acc_now !== 16'd13) begin n_fail++; $display("[TB] FAIL mid_after: got %0d expected 13", acc_now); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rstn      = ($urandom_range(99) != 0);
      if ($urandom_range(3) == 0) cnt_in = CNT_W'($urandom_range(15));
      snap_req  = ($urandom_range(2) == 0);
      out_ready = ($urandom_range(1) == 0);
      step();
      n_checks++;
      if (acc_now !== m_acc) begin n_fail++; $display("[TB] FAIL rand_acc cycle %0d: got %0d expected %0d", i, acc_now, m_acc); end
      n_checks++;
      if (out_valid !== (m_q.size() != 0)) begin n_fail++; $display("[TB] FAIL rand_valid cycle %0d: got %0b expected %0b", i, out_valid, (m_q.size() != 0)); end
      n_checks++;
      if (ovf !== m_ovf) begin n_fail++; $display("[TB] FAIL rand_ovf cycle %0d: got %0b expected %0b", i, ovf, m_ovf); end
      if (m_q.size() != 0) begin
        n_checks++;
        if (out_data !== m_q[0]) begin n_fail++; $display("[TB] FAIL rand_data cycle %0d: got %0d expected %0d", i, out_data, m_q[0]); end
      end
    end
    rstn = 1'b1;
    snap_req = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    rstn      = 1'b0;
    cnt_in    = '0;
    snap_req  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_steps();
    test_wrap();
    test_snapshot();
    test_overflow();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ripple_capture.md
RIPPLE_CAPTURE -- requirements
Module: ripple_capture

Interface
REQ-001 Parameter CNT_W, default 4: width of the sampled ripple count.
REQ-002 Parameter ACC_W, default 16: width of the extended accumulated count.
REQ-003 Parameter DEPTH, default 4 (power of two, >=2): number of snapshot FIFO entries.
REQ-004 Parameter DOWN, default 1: 1 = source counts down (mod 2^CNT_W), 0 = source counts up.
REQ-005 Clock and reset: one clock, clk; reset rstn, synchronous and active-low.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rstn  input  1  synchronous active-low reset.
REQ-008 cnt_in  input  CNT_W  ripple-counter value, asynchronous to clk, may glitch during ripple.
REQ-009 snap_req  input  1  single-cycle request to push the current accumulated count into the FIFO.
REQ-010 out_data  output  ACC_W  FIFO head snapshot.
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 out_ready  input  1  consumer accepts out_data when out_valid is high.
REQ-013 acc_now  output  ACC_W  live accumulated count.
REQ-014 ovf  output  1  sticky flag: a snapshot was dropped.

Function
REQ-015 cnt_in shall pass through a two-flop synchronizer (s1, s2) and a history flop s3 (s3 <= s2).
REQ-016 A sample shall be stable when s2 == s3; unstable samples shall be ignored.
REQ-017 The last accepted value shall be held in a register last; flag primed shall be 0 after reset.
REQ-018 First stable sample with primed == 0: load last, set primed, leave acc unchanged.
REQ-019 Stable sample with primed == 1 and s2 != last: last <= s2; acc <= acc + delta.
REQ-020 delta is computed mod 2^CNT_W: (last - s2) when DOWN = 1, (s2 - last) when DOWN = 0, zero-extended to ACC_W.
REQ-021 acc wraps mod 2^ACC_W with no flag.
REQ-022 Latency: a cnt_in value held constant from edge E is reflected in acc_now after edge E+3 (4th edge counting E).
REQ-023 acc_now is a direct register output.
REQ-024 snap_req high at an edge shall push the acc_now value visible in that cycle (pre-edge), excluding any same-edge update.
REQ-025 Pop occurs when out_valid && out_ready at an edge; out_data shows the next entry or holds when emptied.
REQ-026 FIFO order is strict first-in first-out; out_data is stable while out_valid && !out_ready.
REQ-027 Push when full and no pop in the same cycle: drop the snapshot, set ovf, FIFO unchanged.
REQ-028 Push when full with simultaneous pop: accept both; occupancy stays DEPTH, ovf unchanged.
REQ-029 Push when empty: out_valid rises the following cycle; there is no same-cycle bypass.
REQ-030 ovf shall clear only on reset.

Reset
REQ-031 On rstn low at an edge, the following shall be zeroed: s1, s2, s3, last, primed, acc, FIFO pointers and count, and ovf.
REQ-032 During reset and the cycle after it, out_valid = 0, acc_now = 0, ovf = 0; out_data = 0.
REQ-033 Reset mid-operation discards all FIFO contents and re-arms priming (REQ-018) regardless of cnt_in.

Structure
REQ-034 Package ripple_capture_pkg shall hold CNT_W, ACC_W and DEPTH defaults and the delta helper function.
REQ-035 The FIFO shall be a sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop, full/empty, clk/rstn).
REQ-036 The synchronizer, filter and accumulator shall remain in ripple_capture; no other sub-modules.

Verification
REQ-037 Reset, cnt_in = 9 held -> acc_now = 0 throughout, primed set by the 4th edge, no acc change.
REQ-038 DOWN = 1: after priming at 5, step cnt_in 5->4->3, each held 6 cycles -> acc_now 1 then 2, each 4 edges after the change.
REQ-039 DOWN = 1: cnt_in 0 -> 15 -> acc +1; jump last = 2 to cnt_in = 14 -> acc +4; cnt_in toggling every cycle (never stable) -> acc unchanged.
REQ-040 acc = 7, snap_req for 1 cycle, out_ready = 0 -> out_valid = 1 next cycle, out_data = 7, held until out_ready = 1, then out_valid = 0.
REQ-041 DEPTH = 4, out_ready = 0, 5 snap_req with acc = 1..5 -> ovf = 1, drain yields 1, 2, 3, 4; then full with push + pop together -> ovf stays, order preserved.
REQ-042 rstn low for one cycle with 3 entries queued and acc = 20 -> next cycle out_valid = 0, acc_now = 0, ovf = 0; priming repeats.
